// File: rtl/prog_loader.sv
// Boot-time program loader: reads a length-prefixed image from a flash byte stream into PRAM.
// Optional trailing checksum byte verification is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       start,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       flash_strt,
   output logic       pram_wre,
   output logic [7:0] pram_addr,
   output logic [7:0] pram_data,
   output logic       busy,
   output logic       done,
   output logic [1:0] err_code,
   output logic [7:0] byte_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_LEN, S_LOAD, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

   state_t      state, state_nxt;
   logic [7:0]  len_q, len_nxt;
   logic [15:0] tmo_cnt, tmo_nxt;
   logic [7:0]  cnt_nxt, addr_nxt, data_nxt;
   logic [1:0]  err_nxt;
   logic        wre_nxt;
   logic        tmo_hit;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q, sum_nxt;
`endif

   // A byte arriving in the final idle cycle wins over the timeout.
   assign tmo_hit = (tmo_cnt == TMO_LAST) && !byte_valid;

   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      tmo_nxt   = tmo_cnt;
      cnt_nxt   = byte_count;
      addr_nxt  = pram_addr;
      data_nxt  = pram_data;
      err_nxt   = err_code;
      wre_nxt   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_nxt   = sum_q;
`endif
      if (state inside {S_LEN, S_LOAD, S_CSUM})
         tmo_nxt = byte_valid ? 16'd0 : tmo_cnt + 16'd1;

      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_REQ;
               cnt_nxt   = 8'd0;
               err_nxt   = 2'b00;
               tmo_nxt   = 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_nxt   = 8'd0;
`endif
            end
         end
         S_REQ: state_nxt = S_LEN;
         S_LEN: begin
            if (byte_valid) begin
               if (byte_data == 8'd0) begin
                  state_nxt = S_ERR;
                  err_nxt   = 2'b01;
               end else begin
                  len_nxt   = byte_data;
                  state_nxt = S_LOAD;
               end
            end else if (tmo_hit) begin
               state_nxt = S_ERR;
               err_nxt   = 2'b10;
            end
         end
         S_LOAD: begin
            if (byte_valid) begin
               wre_nxt  = 1'b1;
               addr_nxt = byte_count;
               data_nxt = byte_data;
               cnt_nxt  = byte_count + 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_nxt  = sum_q + byte_data;
               if (byte_count + 8'd1 == len_q) state_nxt = S_CSUM;
`else
               if (byte_count + 8'd1 == len_q) state_nxt = S_DONE;
`endif
            end else if (tmo_hit) begin
               state_nxt = S_ERR;
               err_nxt   = 2'b10;
            end
         end
         S_CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            if (byte_valid) begin
               if (byte_data == sum_q) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_ERR;
                  err_nxt   = 2'b11;
               end
            end else if (tmo_hit) begin
               state_nxt = S_ERR;
               err_nxt   = 2'b10;
            end
`else
            state_nxt = S_DONE;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Register stage: state plus every output, decoded from the next state.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= S_IDLE;
         len_q      <= 8'd0;
         tmo_cnt    <= 16'd0;
         byte_count <= 8'd0;
         pram_wre   <= 1'b0;
         pram_addr  <= 8'd0;
         pram_data  <= 8'd0;
         err_code   <= 2'b00;
         flash_strt <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q      <= 8'd0;
`endif
      end else begin
         state      <= state_nxt;
         len_q      <= len_nxt;
         tmo_cnt    <= tmo_nxt;
         byte_count <= cnt_nxt;
         pram_wre   <= wre_nxt;
         pram_addr  <= addr_nxt;
         pram_data  <= data_nxt;
         err_code   <= err_nxt;
         flash_strt <= (state_nxt == S_REQ);
         busy       <= (state_nxt inside {S_REQ, S_LEN, S_LOAD, S_CSUM});
         done       <= (state_nxt == S_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q      <= sum_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected PRAM writes are queued as bytes are sent
// and matched by a write monitor on the falling edge.
module tb_prog_loader;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       start = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'd0;
   logic       flash_strt, pram_wre, busy, done;
   logic [7:0] pram_addr, pram_data, byte_count;
   logic [1:0] err_code;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int wr_cnt = 0;
   logic [7:0] next_addr = 8'd0;
   logic [7:0] sum = 8'd0;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;
   wr_t exp_q[$];

   prog_loader #(.TIMEOUT_CYCLES(16'd8)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .flash_strt (flash_strt),
      .pram_wre   (pram_wre),
      .pram_addr  (pram_addr),
      .pram_data  (pram_data),
      .busy       (busy),
      .done       (done),
      .err_code   (err_code),
      .byte_count (byte_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit is_payload);
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      byte_valid = 1'b0;
      if (is_payload) begin
         exp_q.push_back('{addr: next_addr, data: b, cyc: cyc});
         next_addr++;
         sum += b;
      end
   endtask

   task automatic start_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      next_addr = 8'd0;
      sum       = 8'd0;
      wr_cnt    = 0;
      tick();
   endtask

   task automatic send_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
      send(sum, 1'b0);
`endif
   endtask

   initial forever begin
      @(posedge sys_clk);
      cyc++;
   end

   initial forever begin
      wr_t e;
      @(negedge sys_clk);
      if (pram_wre !== 1'b0) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check("wr_unexpected_qsize", 32'(exp_q.size()), 1);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(pram_addr), 32'(e.addr));
            check("wr_data", 32'(pram_data), 32'(e.data));
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      #3;
      check("rst_ctrl", 32'({flash_strt, pram_wre, busy, done}), 0);
      check("rst_pram", 32'({pram_addr, pram_data}), 0);
      check("rst_status", 32'({err_code, byte_count}), 0);
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;

      // nominal three-byte image
      start = 1'b1;
      tick();
      start = 1'b0;
      next_addr = 8'd0; sum = 8'd0; wr_cnt = 0;
      check("req_flash_strt", 32'(flash_strt), 1);
      check("req_busy", 32'(busy), 1);
      tick();
      check("len_flash_strt", 32'(flash_strt), 0);
      send(8'h03, 1'b0);
      send(8'hAA, 1'b1);
      send(8'hBB, 1'b1);
      send(8'hCC, 1'b1);
      send_csum();
      check("t1_done", 32'(done), 1);
      check("t1_busy", 32'(busy), 0);
      check("t1_count", 32'(byte_count), 3);
      tick(); tick();
      check("t1_writes", 32'(wr_cnt), 3);
      check("t1_qempty", 32'(exp_q.size()), 0);

      // stray bytes in DONE are ignored
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      tick();
      check("done_hold", 32'(done), 1);
      check("done_count", 32'(byte_count), 3);
      check("done_writes", 32'(wr_cnt), 3);

      // zero length
      start_load();
      send(8'h00, 1'b0);
      check("zlen_err", 32'(err_code), 1);
      check("zlen_busy", 32'(busy), 0);
      check("zlen_done", 32'(done), 0);
      tick(); tick();
      check("zlen_writes", 32'(wr_cnt), 0);

      // timeout after one payload byte; start while busy ignored
      start_load();
      send(8'h02, 1'b0);
      start = 1'b1;
      send(8'h11, 1'b1);
      start = 1'b0;
      check("busy_start_flash", 32'(flash_strt), 0);
      check("busy_start_busy", 32'(busy), 1);
      repeat (7) tick();
      check("tmo_not_yet_err", 32'(err_code), 0);
      check("tmo_not_yet_busy", 32'(busy), 1);
      tick();
      check("tmo_err", 32'(err_code), 2);
      check("tmo_busy", 32'(busy), 0);
      check("tmo_count", 32'(byte_count), 1);
      tick();
      check("tmo_writes", 32'(wr_cnt), 1);

      // byte arriving on the last idle cycle is accepted
      start_load();
      send(8'h03, 1'b0);
      send(8'h21, 1'b1);
      repeat (7) tick();
      send(8'h22, 1'b1);
      check("tmo_edge_err", 32'(err_code), 0);
      check("tmo_edge_busy", 32'(busy), 1);
      send(8'h23, 1'b1);
      send_csum();
      check("tmo_edge_done", 32'(done), 1);
      tick();
      check("tmo_edge_writes", 32'(wr_cnt), 3);

`ifdef PROG_LOADER_CHECKSUM_EN
      start_load();
      send(8'h02, 1'b0);
      send(8'h10, 1'b1);
      send(8'h20, 1'b1);
      send(8'h31, 1'b0);
      check("csum_bad_err", 32'(err_code), 3);
      tick();
      check("csum_bad_writes", 32'(wr_cnt), 2);
      start_load();
      send(8'h02, 1'b0);
      send(8'h10, 1'b1);
      send(8'h20, 1'b1);
      send(8'h30, 1'b0);
      check("csum_ok_done", 32'(done), 1);
      check("csum_ok_err", 32'(err_code), 0);
`endif

      // asynchronous reset in the middle of a load
      start_load();
      send(8'h05, 1'b0);
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      @(negedge sys_clk);
      #1 sys_rst = 1'b1;
      #1;
      check("arst_ctrl", 32'({flash_strt, pram_wre, busy, done}), 0);
      check("arst_pram", 32'({pram_addr, pram_data}), 0);
      check("arst_status", 32'({err_code, byte_count}), 0);
      tick();
      sys_rst = 1'b0;
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      send(8'h05, 1'b0);
      tick();
      check("arst_writes", 32'(wr_cnt), 2);
      check("arst_busy", 32'(busy), 0);
      check("arst_qempty", 32'(exp_q.size()), 0);

      // first load after reset
      start_load();
      send(8'h01, 1'b0);
      send(8'h5A, 1'b1);
      send_csum();
      check("post_rst_done", 32'(done), 1);
      check("post_rst_count", 32'(byte_count), 1);

      // maximum length image
      start_load();
      send(8'hFF, 1'b0);
      for (int i = 0; i < 255; i++) send(8'(i) ^ 8'h5C, 1'b1);
      send_csum();
      check("max_done", 32'(done), 1);
      check("max_count", 32'(byte_count), 255);
      tick();
      check("max_writes", 32'(wr_cnt), 255);
      check("max_qempty", 32'(exp_q.size()), 0);

      tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
